// File: rtl/iob_axi_pkg.sv
// Shared FSM state encoding and AXI protocol constants for the IOb-to-AXI bridge.
package iob_axi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdData
    } axi_state_e;

    localparam logic [1:0] AxiBurstIncr  = 2'b01;
    localparam logic [1:0] AxiRespOkay   = 2'b00;
    localparam logic [1:0] AxiRespSlvErr = 2'b10;
    localparam logic [1:0] AxiRespDecErr = 2'b11;

    function automatic logic [2:0] axi_size(input int unsigned data_w);
        return 3'($clog2(data_w / 8));
    endfunction

    function automatic logic axi_resp_is_err(input logic [1:0] resp);
        return (resp == AxiRespSlvErr) || (resp == AxiRespDecErr);
    endfunction

endpackage

// File: rtl/iob_axi_single_master.sv
// Single-beat AXI4 master driven by an IOb request port; one outstanding
// transaction at a time, reads and writes share one FSM.
module iob_axi_single_master
    import iob_axi_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned AXI_ID_W   = 4,
    parameter int unsigned AXI_LEN_W  = 8,
    parameter int unsigned AXI_ADDR_W = 32
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic                    cke_i,

    input  logic                    iob_avalid_i,
    input  logic [ADDR_W-1:0]       iob_addr_i,
    input  logic [DATA_W-1:0]       iob_wdata_i,
    input  logic [DATA_W/8-1:0]     iob_wstrb_i,
    output logic [DATA_W-1:0]       iob_rdata_o,
    output logic                    iob_rvalid_o,
    output logic                    iob_ready_o,

    output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
    output logic [AXI_ID_W-1:0]     axi_awid_o,
    output logic [AXI_LEN_W-1:0]    axi_awlen_o,
    output logic [2:0]              axi_awsize_o,
    output logic [1:0]              axi_awburst_o,
    output logic                    axi_awvalid_o,
    input  logic                    axi_awready_i,

    output logic [DATA_W-1:0]       axi_wdata_o,
    output logic [DATA_W/8-1:0]     axi_wstrb_o,
    output logic                    axi_wlast_o,
    output logic                    axi_wvalid_o,
    input  logic                    axi_wready_i,

    input  logic [1:0]              axi_bresp_i,
    input  logic                    axi_bvalid_i,
    output logic                    axi_bready_o,

    output logic [AXI_ADDR_W-1:0]   axi_araddr_o,
    output logic [AXI_ID_W-1:0]     axi_arid_o,
    output logic [AXI_LEN_W-1:0]    axi_arlen_o,
    output logic [2:0]              axi_arsize_o,
    output logic [1:0]              axi_arburst_o,
    output logic                    axi_arvalid_o,
    input  logic                    axi_arready_i,

    input  logic [DATA_W-1:0]       axi_rdata_i,
    input  logic [1:0]              axi_rresp_i,
    input  logic                    axi_rlast_i,
    input  logic                    axi_rvalid_i,
    output logic                    axi_rready_o,

    output logic                    err_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    // Single-beat transfers are always size-aligned.
    localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = ~AXI_ADDR_W'(STRB_W - 1);

    axi_state_e              state_q, state_d;
    logic [AXI_ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic                    err_q, err_d;

    // Single-beat bursts make rlast redundant.
    logic unused_rlast;
    assign unused_rlast = axi_rlast_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                if (iob_avalid_i) begin
                    addr_d    = iob_addr_i[AXI_ADDR_W-1:0] & ADDR_MASK;
                    wdata_d   = iob_wdata_i;
                    wstrb_d   = iob_wstrb_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = (|iob_wstrb_i) ? StWrReq : StRdReq;
                end
            end
            StWrReq: begin
                if (axi_awvalid_o && axi_awready_i) aw_done_d = 1'b1;
                if (axi_wvalid_o && axi_wready_i)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)          state_d   = StWrResp;
            end
            StWrResp: begin
                if (axi_bvalid_i) begin
                    if (axi_resp_is_err(axi_bresp_i)) err_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StRdReq: begin
                if (axi_arready_i) state_d = StRdData;
            end
            StRdData: begin
                if (axi_rvalid_i) begin
                    rdata_d  = axi_rdata_i;
                    rvalid_d = 1'b1;
                    if (axi_resp_is_err(axi_rresp_i)) err_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else if (cke_i) begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    assign iob_ready_o   = (state_q == StIdle);
    assign iob_rvalid_o  = rvalid_q;
    assign iob_rdata_o   = rdata_q;
    assign err_o         = err_q;

    assign axi_awaddr_o  = addr_q;
    assign axi_awid_o    = '0;
    assign axi_awlen_o   = '0;
    assign axi_awsize_o  = axi_size(DATA_W);
    assign axi_awburst_o = AxiBurstIncr;
    assign axi_awvalid_o = (state_q == StWrReq) && !aw_done_q;

    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = wstrb_q;
    assign axi_wlast_o   = 1'b1;
    assign axi_wvalid_o  = (state_q == StWrReq) && !w_done_q;

    assign axi_bready_o  = (state_q == StWrResp);

    assign axi_araddr_o  = addr_q;
    assign axi_arid_o    = '0;
    assign axi_arlen_o   = '0;
    assign axi_arsize_o  = axi_size(DATA_W);
    assign axi_arburst_o = AxiBurstIncr;
    assign axi_arvalid_o = (state_q == StRdReq);

    assign axi_rready_o  = (state_q == StRdData);

endmodule

// File: tb/tb_iob_axi_single_master.sv
// Randomized bench for iob_axi_single_master: behavioural AXI RAM slave with
// programmable wait states, byte-level reference memory and sticky-error model.
module tb_iob_axi_single_master;
    import iob_axi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_n = 1'b0;
    logic        cke = 1'b1;
    logic        iob_avalid = 1'b0;
    logic [31:0] iob_addr = '0;
    logic [31:0] iob_wdata = '0;
    logic [3:0]  iob_wstrb = '0;
    logic [31:0] iob_rdata;
    logic        iob_rvalid, iob_ready;

    logic [31:0] awaddr, araddr, wdata, rdata = '0;
    logic [3:0]  awid, arid, wstrb;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp = '0, rresp = '0;
    logic        awvalid, wvalid, wlast, bready, arvalid, rready, err;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b1;

    iob_axi_single_master dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .iob_avalid_i(iob_avalid), .iob_addr_i(iob_addr), .iob_wdata_i(iob_wdata),
        .iob_wstrb_i(iob_wstrb), .iob_rdata_o(iob_rdata), .iob_rvalid_o(iob_rvalid),
        .iob_ready_o(iob_ready),
        .axi_awaddr_o(awaddr), .axi_awid_o(awid), .axi_awlen_o(awlen), .axi_awsize_o(awsize),
        .axi_awburst_o(awburst), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
        .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast), .axi_wvalid_o(wvalid),
        .axi_wready_i(wready),
        .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
        .axi_araddr_o(araddr), .axi_arid_o(arid), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
        .axi_arburst_o(arburst), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
        .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast), .axi_rvalid_i(rvalid),
        .axi_rready_o(rready),
        .err_o(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Power-on contents of the RAM, shared by slave and model.
    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // ---------------- Behavioural AXI RAM slave ----------------
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  bresp_cfg = AxiRespOkay, rresp_cfg = AxiRespOkay;
    int          n_aw = 0, n_w = 0, n_b = 0, n_ar = 0;
    logic [31:0] aw_seen, ar_seen, w_seen_data;
    logic [3:0]  w_seen_strb;
    logic [16:0] aw_fields, ar_fields;
    logic        w_seen_last;
    logic [7:0]  smem [logic [31:0]];

    bit got_aw = 0, got_w = 0, b_pend = 0, r_pend = 0;
    int aw_age = 0, w_age = 0, b_age = 0, ar_age = 0, r_age = 0;

    always @(negedge clk) begin
        if (!arst_n) begin
            got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
            aw_age = 0; w_age = 0; b_age = 0; ar_age = 0; r_age = 0;
            awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        end else if (!cke) begin
            awready = 0; wready = 0; arready = 0;
        end else begin
            if (b_pend) begin
                if (b_age >= b_wait) begin
                    bvalid = 1; bresp = bresp_cfg;
                    if (bready) begin b_pend = 0; n_b++; end
                end else begin bvalid = 0; b_age++; end
            end else bvalid = 0;

            if (r_pend) begin
                if (r_age >= r_wait) begin
                    rvalid = 1; rresp = rresp_cfg; rlast = 1;
                    for (int i = 0; i < 4; i++) begin
                        logic [31:0] a;
                        a = {ar_seen[31:2], 2'(i)};
                        rdata[8*i +: 8] = smem.exists(a) ? smem[a] : init_byte(a);
                    end
                    if (rready) r_pend = 0;
                end else begin rvalid = 0; r_age++; end
            end else rvalid = 0;

            if (awvalid && !got_aw) begin
                awready = (aw_age >= aw_wait);
                if (awready) begin
                    got_aw = 1; n_aw++; aw_seen = awaddr;
                    aw_fields = {awid, awlen, awsize, awburst};
                end else aw_age++;
            end else awready = 0;

            if (wvalid && !got_w) begin
                wready = (w_age >= w_wait);
                if (wready) begin
                    got_w = 1; n_w++; w_seen_data = wdata; w_seen_strb = wstrb;
                    w_seen_last = wlast;
                end else w_age++;
            end else wready = 0;

            if (got_aw && got_w) begin
                for (int i = 0; i < 4; i++)
                    if (w_seen_strb[i]) smem[{aw_seen[31:2], 2'(i)}] = w_seen_data[8*i +: 8];
                got_aw = 0; got_w = 0; aw_age = 0; w_age = 0;
                b_pend = 1; b_age = 0;
            end

            if (arvalid) begin
                arready = (ar_age >= ar_wait);
                if (arready) begin
                    n_ar++; ar_seen = araddr; ar_fields = {arid, arlen, arsize, arburst};
                    r_pend = 1; r_age = 0; ar_age = 0;
                end else ar_age++;
            end else arready = 0;
        end
    end

    // ---------------- Reference model ----------------
    logic [7:0] model_mem [logic [31:0]];
    bit         model_err = 0;
    localparam logic [16:0] FIXED_FIELDS = {4'h0, 8'h00, 3'd2, 2'b01};

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = {addr[31:2], 2'(i)};
            w[8*i +: 8] = model_mem.exists(a) ? model_mem[a] : init_byte(a);
        end
        return w;
    endfunction

    task automatic set_waits(input int aw, input int w, input int b, input int ar, input int r);
        aw_wait = aw; w_wait = w; b_wait = b; ar_wait = ar; r_wait = r;
    endtask

    task automatic iob_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int freeze, output int lat);
        int  base_aw, base_w, base_b;
        bit  saw_rv;
        base_aw = n_aw; base_w = n_w; base_b = n_b; saw_rv = 0;
        check_eq("wr_ready_pre", iob_ready, 1'b1);
        iob_avalid = 1; iob_addr = addr; iob_wdata = data; iob_wstrb = strb;
        @(posedge clk); #1;
        iob_avalid = 0; iob_wstrb = '0; lat = 1;
        if (freeze > 0) begin
            cke = 0;
            repeat (freeze) begin
                @(posedge clk); #1; lat++;
                check_eq("frz_valids", {awvalid, wvalid, iob_ready}, 3'b110);
                check_eq("frz_awaddr", awaddr, addr & ~32'h3);
            end
            cke = 1;
        end
        while (!iob_ready && lat < 200) begin
            if (iob_rvalid) saw_rv = 1;
            @(posedge clk); #1; lat++;
        end
        if (iob_rvalid) saw_rv = 1;
        check_eq("wr_done", iob_ready, 1'b1);
        check_eq("wr_no_rvalid", saw_rv, 1'b0);
        check_eq("wr_counts", {8'(n_aw - base_aw), 8'(n_w - base_w), 8'(n_b - base_b)},
                 24'h010101);
        check_eq("wr_awaddr", aw_seen, addr & ~32'h3);
        check_eq("wr_wbeat", {w_seen_last, w_seen_strb, w_seen_data}, {1'b1, strb, data});
        check_eq("wr_fields", aw_fields, FIXED_FIELDS);
        for (int i = 0; i < 4; i++)
            if (strb[i]) model_mem[{addr[31:2], 2'(i)}] = data[8*i +: 8];
        if (bresp_cfg[1]) model_err = 1;
        check_eq("wr_err", err, model_err);
    endtask

    task automatic iob_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
        int base_ar;
        bit saw_ready;
        base_ar = n_ar; saw_ready = 0;
        check_eq("rd_ready_pre", iob_ready, 1'b1);
        iob_avalid = 1; iob_addr = addr; iob_wstrb = '0;
        @(posedge clk); #1;
        iob_avalid = 0; lat = 1;
        while (!iob_rvalid && lat < 200) begin
            if (iob_ready) saw_ready = 1;
            @(posedge clk); #1; lat++;
        end
        check_eq("rd_rvalid", iob_rvalid, 1'b1);
        check_eq("rd_ready_wait", saw_ready, 1'b0);
        check_eq("rd_ready_done", iob_ready, 1'b1);
        data = iob_rdata;
        check_eq("rd_data", data, model_word(addr));
        check_eq("rd_ar_count", 8'(n_ar - base_ar), 8'd1);
        check_eq("rd_araddr", ar_seen, addr & ~32'h3);
        check_eq("rd_fields", ar_fields, FIXED_FIELDS);
        if (rresp_cfg[1]) model_err = 1;
        check_eq("rd_err", err, model_err);
        @(posedge clk); #1;
        check_eq("rd_rvalid_pulse", iob_rvalid, 1'b0);
        check_eq("rd_hold", iob_rdata, data);
    endtask

    initial begin
        int          lat, k;
        logic [31:0] rd, a, d;
        logic [3:0]  s;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_outputs", {awvalid, wvalid, arvalid, bready, rready, iob_rvalid, err},
                 7'b0);
        check_eq("rst_rdata", iob_rdata, 32'h0);
        arst_n = 1;
        @(posedge clk); #1;
        check_eq("rst_ready", iob_ready, 1'b1);

        set_waits(0, 0, 0, 0, 0);
        iob_write(32'h0000_1007, 32'hDEAD_BEEF, 4'hF, 0, lat);
        check_eq("wr_latency", lat, 3);
        check_eq("wr_awaddr_1004", aw_seen, 32'h1004);
        iob_read(32'h0000_1004, rd, lat);
        check_eq("rd_latency", lat, 3);
        check_eq("rd_deadbeef", rd, 32'hDEAD_BEEF);

        set_waits(4, 0, 0, 0, 0);  // W first, AW 4 cycles later
        iob_write(32'h0000_1100, 32'hA5A5_0001, 4'hF, 0, lat);
        set_waits(0, 3, 1, 0, 0);  // AW first
        iob_write(32'h0000_1104, 32'hA5A5_0002, 4'h5, 0, lat);
        set_waits(2, 2, 0, 0, 0);  // same-cycle after waits
        iob_write(32'h0000_1108, 32'hA5A5_0003, 4'hA, 0, lat);

        set_waits(0, 0, 0, 0, 0);
        iob_write(32'h0000_3000, 32'h1234_5678, 4'hF, 0, lat);
        set_waits(0, 0, 0, 0, 10);
        iob_read(32'h0000_3000, rd, lat);
        check_eq("rd_slow_data", rd, 32'h1234_5678);

        set_waits(0, 0, 0, 0, 0);
        iob_write(32'h0000_3004, 32'hCAFE_F00D, 4'hF, 5, lat);
        check_eq("frz_latency", lat - 5, 3);
        iob_read(32'h0000_3004, rd, lat);

        bresp_cfg = AxiRespSlvErr;
        iob_write(32'h0000_3008, 32'h0BAD_0BAD, 4'hF, 0, lat);
        check_eq("err_set", err, 1'b1);
        bresp_cfg = AxiRespOkay;
        iob_write(32'h0000_300C, 32'h600D_600D, 4'hF, 0, lat);
        iob_read(32'h0000_3008, rd, lat);
        check_eq("err_sticky", err, 1'b1);

        for (int t = 0; t < 40; t++) begin
            set_waits($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            bresp_cfg = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : AxiRespOkay;
            rresp_cfg = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : AxiRespOkay;
            a = 32'h2000 + 32'($urandom_range(0, 63));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if (s != 0) iob_write(a, d, s, 0, lat);
            else        iob_read(a, rd, lat);
        end
        bresp_cfg = AxiRespOkay;
        rresp_cfg = AxiRespOkay;

        // Reset while waiting on read data.
        set_waits(0, 0, 0, 0, 20);
        iob_avalid = 1; iob_addr = 32'h2000; iob_wstrb = '0;
        @(posedge clk); #1;
        iob_avalid = 0;
        k = 0;
        while (!rready && k < 50) begin @(posedge clk); #1; k++; end
        check_eq("mid_rd_data", rready, 1'b1);
        arst_n = 0;
        #1;
        check_eq("mid_rst_outputs",
                 {awvalid, wvalid, arvalid, bready, rready, iob_rvalid, err}, 7'b0);
        check_eq("mid_rst_rdata", iob_rdata, 32'h0);
        model_err = 0;
        @(posedge clk); #1;
        arst_n = 1;
        @(posedge clk); #1;
        check_eq("mid_rst_ready", {iob_ready, awvalid, wvalid, arvalid}, 4'b1000);
        set_waits(0, 0, 0, 0, 0);
        iob_write(32'h0000_4000, 32'h7777_1234, 4'hF, 0, lat);
        check_eq("post_rst_wr_lat", lat, 3);
        iob_read(32'h0000_4000, rd, lat);
        check_eq("post_rst_rd", rd, 32'h7777_1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
